data_distributor: RTL and testbench
===================================

DATA_DISTRIBUTOR -- requirements
Module: data_distributor

Interface
REQ-001 The module SHALL have parameter PORT_NUM, default 5, giving the number of output ports (range 2..16).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 5, giving the payload width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port flush, input, 1 bit: discards all held output entries.
REQ-006 Port data_in_sel, input, PORT_NUM bits: target port mask; bit i selects port i; multiple set bits mean broadcast.
REQ-007 Port data_in, input, DATA_WIDTH bits: payload.
REQ-008 Port data_in_valid, input, 1 bit: the input item is present.
REQ-009 Port data_in_ready, output, 1 bit: the input item is accepted this cycle when data_in_valid is also high.
REQ-010 Port data_out, output, array [0:PORT_NUM-1] of DATA_WIDTH bits: per-port held payload.
REQ-011 Port data_out_valid, output, PORT_NUM bits: per-port held-entry valid.
REQ-012 Port data_out_ready, input, PORT_NUM bits: per-port consumer ready.
REQ-013 Port drop_count, output, 8 bits: count of accepted items with an all-zero data_in_sel.

Function
REQ-014 Each port i SHALL own one holding register (payload plus valid bit); data_out[i] and data_out_valid[i] SHALL be driven directly from that register.
REQ-015 Port i SHALL be able to accept in a cycle when its register is empty, or when it is full and data_out_ready[i] is high (drain and refill in the same cycle).
REQ-016 data_in_ready SHALL be high when flush is low and every port selected by data_in_sel can accept.
REQ-017 data_in_ready SHALL be combinational from data_in_sel, data_out_valid, data_out_ready and flush.
REQ-018 data_in_ready SHALL NOT depend on data_in_valid.
REQ-019 On an input transfer (data_in_valid and data_in_ready both high), every selected port SHALL load data_in and set its valid bit at the next edge; the latency from transfer to data_out_valid[i] is 1 cycle.
REQ-020 Broadcast SHALL be atomic: an item is written to all of its selected ports in the same cycle, or to none of them.
REQ-021 An output transfer on port i (data_out_valid[i] and data_out_ready[i] both high) SHALL clear valid bit i at the next edge, unless port i is reloaded in the same cycle.
REQ-022 Unselected ports SHALL hold their contents; ports SHALL be independent and may drain in any order.
REQ-023 data_out[i] SHALL stay stable while data_out_valid[i] is high and data_out_ready[i] is low.
REQ-024 An all-zero data_in_sel SHALL be accepted (data_in_ready high unless flush is high) and the payload discarded.
REQ-025 Each such discarded transfer SHALL increment drop_count; drop_count SHALL saturate at 255, with no wrap.
REQ-026 flush high SHALL clear all valid bits at the next edge and force data_in_ready low.
REQ-027 Output transfers in a flush cycle SHALL still count as completed for the consumer.
REQ-028 flush SHALL NOT change drop_count.
REQ-029 Invalid payload registers are don't-care; data_out[i] SHALL only be interpreted when data_out_valid[i] is high.

Reset
REQ-030 While rst is low at a rising edge, all valid bits SHALL become 0, all payload registers 0, and drop_count 0.
REQ-031 A reset applied mid-transfer SHALL win over any simultaneous load, drain or flush.
REQ-032 data_in_ready SHALL be low while rst is low.
REQ-033 In the first cycle after reset release, data_in_ready SHALL follow REQ-016, with all ports empty.

Verification
REQ-034 Single route (PORT_NUM=5): sel=00100, data=0x15, valid=1, all ready=0 -> data_in_ready=1; next cycle data_out_valid=00100 and data_out[2]=0x15.
REQ-035 Backpressure: port 2 full, ready[2]=0, new item with sel=00100 -> data_in_ready=0; port 2 holds 0x15; raising ready[2] -> data_in_ready=1 the same cycle, port 2 reloads and stays valid.
REQ-036 Broadcast: sel=10011, port 4 full and not ready -> data_in_ready=0 and ports 0 and 1 stay empty; when port 4 drains, all three ports load in the same cycle.
REQ-037 Drop: 260 transfers with sel=00000 -> data_in_ready=1 throughout, data_out_valid unchanged, drop_count=255.
REQ-038 Flush: ports 0 and 3 full, flush=1 with valid=1 and sel=00010 -> data_in_ready=0; next cycle data_out_valid=00000.
REQ-039 Reset: rst low during a transfer with ports 1 and 2 full -> next cycle data_out_valid=00000, drop_count=0, and data_in_ready low until rst goes high.

Source files
------------

// File: rtl/data_distributor_if.sv
// Handshake bundle between one producer and the per-port consumers of a data_distributor.
interface data_distributor_if #(
  parameter int PORT_NUM   = 5,
  parameter int DATA_WIDTH = 5
);
  logic [PORT_NUM-1:0]   data_in_sel;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out [0:PORT_NUM-1];
  logic [PORT_NUM-1:0]   data_out_valid;
  logic [PORT_NUM-1:0]   data_out_ready;

  modport master (
    output data_in_sel, data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in_sel, data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/data_distributor.sv
// Routes each input item to one or more single-entry output ports (atomic broadcast),
// counting discarded items that name no port.
module data_distributor #(
  parameter int PORT_NUM   = 5,
  parameter int DATA_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  data_distributor_if.slave    bus,
  output logic [7:0]           drop_count
);

  logic [PORT_NUM-1:0] can_accept;
  logic [PORT_NUM-1:0] load;
  logic                in_fire;
  logic                is_drop;

  // A port can take a new item if it is empty or is being drained this cycle;
  // the item goes only when every selected port can take it, so broadcast is all-or-nothing.
  assign can_accept        = ~bus.data_out_valid | bus.data_out_ready;
  assign bus.data_in_ready = rst & ~flush & ((bus.data_in_sel & ~can_accept) == '0);
  assign in_fire           = bus.data_in_valid & bus.data_in_ready;
  assign load              = in_fire ? bus.data_in_sel : '0;
  assign is_drop           = in_fire & (bus.data_in_sel == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        bus.data_out[i] <= '0;
      end
      bus.data_out_valid <= '0;
      drop_count         <= '0;
    end else begin
      // A reload beats a drain on the same port; flush never coincides with a load.
      for (int i = 0; i < PORT_NUM; i++) begin
        if (load[i]) begin
          bus.data_out[i]       <= bus.data_in;
          bus.data_out_valid[i] <= 1'b1;
        end else if (flush || bus.data_out_ready[i]) begin
          bus.data_out_valid[i] <= 1'b0;
        end
      end
      if (is_drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_distributor.sv
// Randomized and directed bench for data_distributor, checked every cycle against a
// vector-level behavioural model.
module tb_data_distributor;
  localparam int P = 5;
  localparam int W = 5;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] drop_count;

  data_distributor_if #(.PORT_NUM(P), .DATA_WIDTH(W)) bus ();

  data_distributor #(.PORT_NUM(P), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus.slave),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  // Reference state: which ports hold an item, what they hold, and the drop tally.
  logic [P-1:0] m_valid;
  logic [W-1:0] m_data [0:P-1];
  logic [7:0]   m_drop;
  logic         m_init = 1'b0;
  logic         m_ready;
  logic         m_accept;
  logic [P-1:0] m_next_valid;

  // The item is refused if any selected port is still holding something that is not leaving.
  always_comb begin
    m_ready = rst && !flush && ((bus.data_in_sel & m_valid & ~bus.data_out_ready) == '0);
    m_accept = bus.data_in_valid && m_ready;
    m_next_valid = flush ? '0 : (m_valid & ~bus.data_out_ready);
    if (m_accept) m_next_valid = m_next_valid | bus.data_in_sel;
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_valid <= '0;
      m_drop  <= 8'd0;
      m_init  <= 1'b1;
      for (int i = 0; i < P; i++) m_data[i] <= '0;
    end else begin
      m_valid <= m_next_valid;
      for (int i = 0; i < P; i++)
        if (m_accept && bus.data_in_sel[i]) m_data[i] <= bus.data_in;
      if (m_accept && bus.data_in_sel == '0)
        m_drop <= (m_drop == 8'd255) ? 8'd255 : m_drop + 8'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("model ready", 32'(bus.data_in_ready), 32'(m_ready));
      checkOutput("model valid", 32'(bus.data_out_valid), 32'(m_valid));
      checkOutput("model drop", 32'(drop_count), 32'(m_drop));
      for (int i = 0; i < P; i++)
        if (m_valid[i]) checkOutput($sformatf("model data[%0d]", i), 32'(bus.data_out[i]), 32'(m_data[i]));
    end
  end

  // Inputs change just after a rising edge and are observed at the following falling edge.
  task automatic applyStimulus(input logic [P-1:0] sel, input logic [W-1:0] dat, input logic vld,
                               input logic [P-1:0] rdy, input logic fl, input logic rs);
    @(posedge clk);
    #1;
    bus.data_in_sel    = sel;
    bus.data_in        = dat;
    bus.data_in_valid  = vld;
    bus.data_out_ready = rdy;
    flush              = fl;
    rst                = rs;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.data_in_sel = '0;
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    bus.data_out_ready = '0;

    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("reset ready", 32'(bus.data_in_ready), 32'd0);
    checkOutput("reset valid", 32'(bus.data_out_valid), 32'd0);
    checkOutput("reset drop", 32'(drop_count), 32'd0);

    // Single route to port 2.
    applyStimulus(5'b00100, 5'h15, 1'b1, 5'b00000, 1'b0, 1'b1);
    checkOutput("route ready", 32'(bus.data_in_ready), 32'd1);
    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b1);
    checkOutput("route valid", 32'(bus.data_out_valid), 32'b00100);
    checkOutput("route data", 32'(bus.data_out[2]), 32'h15);

    // Backpressure, then drain-and-refill on port 2.
    applyStimulus(5'b00100, 5'h0A, 1'b1, 5'b00000, 1'b0, 1'b1);
    checkOutput("bp ready low", 32'(bus.data_in_ready), 32'd0);
    checkOutput("bp hold", 32'(bus.data_out[2]), 32'h15);
    applyStimulus(5'b00100, 5'h0A, 1'b1, 5'b00100, 1'b0, 1'b1);
    checkOutput("bp ready high", 32'(bus.data_in_ready), 32'd1);
    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b1);
    checkOutput("bp reload valid", 32'(bus.data_out_valid), 32'b00100);
    checkOutput("bp reload data", 32'(bus.data_out[2]), 32'h0A);

    // Broadcast blocked by port 4, then released.
    applyStimulus(5'b10000, 5'h07, 1'b1, 5'b00000, 1'b0, 1'b1);
    applyStimulus(5'b10011, 5'h1C, 1'b1, 5'b00000, 1'b0, 1'b1);
    checkOutput("bc blocked", 32'(bus.data_in_ready), 32'd0);
    applyStimulus(5'b10011, 5'h1C, 1'b1, 5'b00000, 1'b0, 1'b1);
    checkOutput("bc atomic", 32'(bus.data_out_valid), 32'b10100);
    applyStimulus(5'b10011, 5'h1C, 1'b1, 5'b10000, 1'b0, 1'b1);
    checkOutput("bc release", 32'(bus.data_in_ready), 32'd1);
    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b1);
    checkOutput("bc valid", 32'(bus.data_out_valid), 32'b10111);
    checkOutput("bc data0", 32'(bus.data_out[0]), 32'h1C);
    checkOutput("bc data4", 32'(bus.data_out[4]), 32'h1C);

    // Saturating drop counter.
    for (int n = 0; n < 260; n++) begin
      applyStimulus(5'b00000, 5'($urandom), 1'b1, 5'b00000, 1'b0, 1'b1);
      checkOutput("drop ready", 32'(bus.data_in_ready), 32'd1);
    end
    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b1);
    checkOutput("drop saturate", 32'(drop_count), 32'd255);
    checkOutput("drop valid kept", 32'(bus.data_out_valid), 32'b10111);

    // Flush.
    applyStimulus(5'b00010, 5'h03, 1'b1, 5'b00000, 1'b1, 1'b1);
    checkOutput("flush ready", 32'(bus.data_in_ready), 32'd0);
    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b1);
    checkOutput("flush valid", 32'(bus.data_out_valid), 32'd0);
    checkOutput("flush drop kept", 32'(drop_count), 32'd255);

    // Reset during a transfer.
    applyStimulus(5'b00110, 5'h11, 1'b1, 5'b00000, 1'b0, 1'b1);
    applyStimulus(5'b00001, 5'h03, 1'b1, 5'b00110, 1'b0, 1'b0);
    checkOutput("rst ready low", 32'(bus.data_in_ready), 32'd0);
    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b0);
    checkOutput("rst valid", 32'(bus.data_out_valid), 32'd0);
    checkOutput("rst drop", 32'(drop_count), 32'd0);
    checkOutput("rst ready held", 32'(bus.data_in_ready), 32'd0);
    applyStimulus(5'b00000, 5'h00, 1'b0, 5'b00000, 1'b0, 1'b1);
    checkOutput("post-rst ready", 32'(bus.data_in_ready), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom),
                    5'($urandom),
                    1'($urandom_range(0, 3) != 0),
                    5'($urandom),
                    1'($urandom_range(0, 24) == 0),
                    1'($urandom_range(0, 99) != 0));
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
